// File: rtl/multiboot_sequencer_if.sv
// ---------------------------------------------------------------------------
// multiboot_sequencer_if : boot request / USB detach / warm-boot signal group
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface multiboot_sequencer_if;
  logic       boot_req;
  logic       boot_use_sel;
  logic [1:0] boot_sel;
  logic       boot_ack;
  logic       boot_err;
  logic       busy;
  logic       usb_pu_en;
  logic       tx_inhibit;
  logic       wb_s1;
  logic       wb_s0;
  logic       wb_boot;

  modport slave (
    input  boot_req, boot_use_sel, boot_sel,
    output boot_ack, boot_err, busy, usb_pu_en, tx_inhibit, wb_s1, wb_s0, wb_boot
  );

  modport master (
    output boot_req, boot_use_sel, boot_sel,
    input  boot_ack, boot_err, busy, usb_pu_en, tx_inhibit, wb_s1, wb_s0, wb_boot
  );
endinterface

`default_nettype wire

// File: rtl/multiboot_sequencer.sv
// ---------------------------------------------------------------------------
// multiboot_sequencer : timed USB detach followed by iCE40 warm-boot into a
// selectable image. Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module multiboot_sequencer #(
  parameter int NUM_IMAGES     = 4,
  parameter int DEFAULT_IMAGE  = 1,
  parameter int CONNECT_CYCLES = 4800000,
  parameter int DETACH_CYCLES  = 4800000,
  parameter int SETTLE_CYCLES  = 48,
  parameter int CNT_W          = 23
) (
  input  logic                  clk_48mhz,
  input  logic                  reset_n,
  multiboot_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {
    ST_CONNECT_WAIT = 3'd0,
    ST_READY        = 3'd1,
    ST_SETTLE       = 3'd2,
    ST_DETACH       = 3'd3,
    ST_BOOT         = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] CONNECT_LAST = CNT_W'(CONNECT_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DETACH_LAST  = CNT_W'(DETACH_CYCLES - 1);
  localparam logic [1:0]       DEFAULT_IDX  = 2'(DEFAULT_IMAGE);
  localparam logic [2:0]       NUM_IMG      = 3'(NUM_IMAGES);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       image_q, image_d;
  logic             boot_ack_q, boot_ack_d;
  logic             boot_err_q, boot_err_d;
  logic             usb_pu_en_q, usb_pu_en_d;
  logic             tx_inhibit_q, tx_inhibit_d;
  logic             busy_q, busy_d;
  logic             wb_boot_q, wb_boot_d;

  logic [1:0]       req_idx;
  logic             req_idx_ok;

  assign req_idx    = bus.boot_use_sel ? bus.boot_sel : DEFAULT_IDX;
  assign req_idx_ok = ({1'b0, req_idx} < NUM_IMG);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    image_d    = image_q;
    boot_ack_d = 1'b0;
    boot_err_d = 1'b0;

    case (state_q)
      ST_CONNECT_WAIT: begin
        if (cnt_q == CONNECT_LAST) begin
          state_d = ST_READY;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_READY: begin
        if (bus.boot_req) begin
          if (req_idx_ok) begin
            state_d    = ST_SETTLE;
            cnt_d      = '0;
            image_d    = req_idx;
            boot_ack_d = 1'b1;
          end else begin
            boot_err_d = 1'b1;
          end
        end
      end
      ST_SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          state_d = ST_DETACH;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DETACH: begin
        if (cnt_q == DETACH_LAST) begin
          state_d = ST_BOOT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_BOOT: begin
        // Terminal: the FPGA reconfigures, only reset leaves this state.
        cnt_d = '0;
      end
      default: begin
        state_d = ST_CONNECT_WAIT;
        cnt_d   = '0;
      end
    endcase

    if (bus.boot_req && (state_q != ST_READY)) begin
      boot_err_d = 1'b1;
    end

    // Outputs follow the next state so they are registered with it.
    usb_pu_en_d  = (state_d == ST_READY) || (state_d == ST_SETTLE);
    tx_inhibit_d = (state_d != ST_READY);
    busy_d       = (state_d != ST_READY);
    wb_boot_d    = (state_d == ST_BOOT);
  end

  always_ff @(posedge clk_48mhz) begin
    if (!reset_n) begin
      state_q      <= ST_CONNECT_WAIT;
      cnt_q        <= '0;
      image_q      <= DEFAULT_IDX;
      boot_ack_q   <= 1'b0;
      boot_err_q   <= 1'b0;
      usb_pu_en_q  <= 1'b0;
      tx_inhibit_q <= 1'b1;
      busy_q       <= 1'b1;
      wb_boot_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      image_q      <= image_d;
      boot_ack_q   <= boot_ack_d;
      boot_err_q   <= boot_err_d;
      usb_pu_en_q  <= usb_pu_en_d;
      tx_inhibit_q <= tx_inhibit_d;
      busy_q       <= busy_d;
      wb_boot_q    <= wb_boot_d;
    end
  end

  assign bus.boot_ack   = boot_ack_q;
  assign bus.boot_err   = boot_err_q;
  assign bus.busy       = busy_q;
  assign bus.usb_pu_en  = usb_pu_en_q;
  assign bus.tx_inhibit = tx_inhibit_q;
  assign bus.wb_s1      = image_q[1];
  assign bus.wb_s0      = image_q[0];
  assign bus.wb_boot    = wb_boot_q;

endmodule

`default_nettype wire

// File: tb/tb_multiboot_sequencer.sv
// ---------------------------------------------------------------------------
// tb_multiboot_sequencer : directed + randomized bench against a timeline model
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_multiboot_sequencer;
  localparam int NUM  = 3;
  localparam int DEF  = 1;
  localparam int CONN = 8;
  localparam int DET  = 16;
  localparam int SET  = 4;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  multiboot_sequencer_if bus();

  multiboot_sequencer #(
    .NUM_IMAGES     (NUM),
    .DEFAULT_IMAGE  (DEF),
    .CONNECT_CYCLES (CONN),
    .DETACH_CYCLES  (DET),
    .SETTLE_CYCLES  (SET),
    .CNT_W          (5)
  ) dut (
    .clk_48mhz (clk),
    .reset_n   (reset_n),
    .bus       (bus)
  );

  int pass_cnt  = 0;
  int total_cnt = 0;

  // Timeline model: everything is derived from the edge of the last reset
  // and the edge at which a request was accepted.
  int         edge_n   = 0;
  int         rst_edge = 0;
  int         acc_edge = -1;
  logic [1:0] m_img    = 2'(DEF);
  logic       m_ack    = 1'b0;
  logic       m_err    = 1'b0;

  task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s at edge %0d: observed %b expected %b", tag, edge_n, obs, exp);
  endtask

  task automatic check_all();
    bit conn, ready, settle, boot;
    int d;
    conn   = (acc_edge < 0) && (edge_n - rst_edge < CONN);
    ready  = (acc_edge < 0) && !conn;
    d      = edge_n - acc_edge;
    settle = (acc_edge >= 0) && (d < SET);
    boot   = (acc_edge >= 0) && (d >= SET + DET);
    chk("usb_pu_en",  {1'b0, bus.usb_pu_en},  {1'b0, ready || settle});
    chk("tx_inhibit", {1'b0, bus.tx_inhibit}, {1'b0, !ready});
    chk("busy",       {1'b0, bus.busy},       {1'b0, !ready});
    chk("wb_boot",    {1'b0, bus.wb_boot},    {1'b0, boot});
    chk("image",      {bus.wb_s1, bus.wb_s0}, m_img);
    chk("boot_ack",   {1'b0, bus.boot_ack},   {1'b0, m_ack});
    chk("boot_err",   {1'b0, bus.boot_err},   {1'b0, m_err});
    chk("ack_err_excl", {1'b0, bus.boot_ack & bus.boot_err}, 2'b00);
  endtask

  task automatic step();
    bit         ready_before;
    logic [1:0] idx;
    @(posedge clk);
    edge_n++;
    m_ack = 1'b0;
    m_err = 1'b0;
    idx   = bus.boot_use_sel ? bus.boot_sel : 2'(DEF);
    if (!reset_n) begin
      rst_edge = edge_n;
      acc_edge = -1;
      m_img    = 2'(DEF);
    end else if (bus.boot_req) begin
      ready_before = (acc_edge < 0) && (edge_n - 1 - rst_edge >= CONN);
      if (ready_before && (int'(idx) < NUM)) begin
        m_ack    = 1'b1;
        acc_edge = edge_n;
        m_img    = idx;
      end else begin
        m_err = 1'b1;
      end
    end
    @(negedge clk);
    check_all();
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic request(input logic use_sel, input logic [1:0] sel);
    bus.boot_req     = 1'b1;
    bus.boot_use_sel = use_sel;
    bus.boot_sel     = sel;
    step();
    bus.boot_req     = 1'b0;
    bus.boot_use_sel = 1'b0;
    bus.boot_sel     = 2'b00;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    steps(2);
    reset_n = 1'b1;
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    reset_n          = 1'b0;
    bus.boot_req     = 1'b0;
    bus.boot_use_sel = 1'b0;
    bus.boot_sel     = 2'b00;

    // Reset release, connect delay
    do_reset();
    steps(CONN + 2);

    // Out-of-range index rejected while READY
    request(1'b1, 2'd3);
    steps(3);

    // Accepted request with explicit latency measurement
    request(1'b1, 2'd2);
    lat = 1;
    while (!bus.wb_boot && lat < 40) begin
      step();
      lat++;
    end
    chk("latency", 2'(lat == 21), 2'b01);
    steps(3);

    // Requests during SETTLE and DETACH are rejected without disturbing timing
    do_reset();
    steps(CONN + 1);
    request(1'b1, 2'd2);
    steps(1);
    request(1'b1, 2'd0);
    steps(SET + 3);
    request(1'b0, 2'd0);
    steps(DET + 3);
    request(1'b1, 2'd1);
    steps(2);

    // Reset in the middle of DETACH
    do_reset();
    steps(CONN + 1);
    request(1'b1, 2'd0);
    steps(SET + 5);
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    steps(2);

    // Default-image request while connecting, then again once READY
    request(1'b0, 2'd3);
    steps(CONN);
    request(1'b0, 2'd3);
    steps(SET + DET + 3);

    // Randomized traffic, including resets at arbitrary points
    for (int i = 0; i < 1500; i++) begin
      reset_n          = ($urandom_range(0, 39) != 0);
      bus.boot_req     = ($urandom_range(0, 5) == 0);
      bus.boot_use_sel = $urandom_range(0, 1) == 1;
      bus.boot_sel     = 2'($urandom_range(0, 3));
      step();
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

`default_nettype wire
